// File: rtl/uart_txer.sv
`timescale 1ns/1ps
// 8N1 UART transmitter with a one-byte holding buffer so frames run back to back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_txer #(
    parameter int CLKS_PER_BIT = 5000
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] data_in,
    input  logic       en_data_in,
    output logic       ready,
    output logic       TX,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    sr_reg, sr_next;
    logic          tx_reg, tx_next;
    logic [7:0]    buf_reg, buf_next;
    logic          buf_valid_reg, buf_valid_next;
    logic          wrap;
    logic          load;

`ifdef UART_TX_PARITY_EN
    logic       parity_reg, parity_next;
    logic [8:0] par_chain;

    // Even parity of the buffered byte, ready when the byte moves into the shifter.
    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ buf_reg[gi];
        end
    endgenerate
`endif

    assign wrap    = (cnt_reg == CNT_LAST);
    assign ready   = !buf_valid_reg;
    assign TX      = tx_reg;
    assign tx_done = (state_reg == S_STOP) && wrap;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_next       = bit_reg;
        sr_next        = sr_reg;
        tx_next        = tx_reg;
        buf_next       = buf_reg;
        buf_valid_next = buf_valid_reg;
        load           = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif

        if (en_data_in && !buf_valid_reg) begin
            buf_next       = data_in;
            buf_valid_next = 1'b1;
        end

        if (state_reg != S_IDLE) begin
            cnt_next = wrap ? '0 : cnt_reg + CW'(1);
        end

        case (state_reg)
            S_IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                load     = buf_valid_reg;
            end
            S_START: begin
                if (wrap) begin
                    tx_next    = sr_reg[0];
                    bit_next   = 3'd0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = S_PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = S_STOP;
`endif
                    end else begin
                        sr_next  = {1'b0, sr_reg[7:1]};
                        tx_next  = sr_reg[1];
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (wrap) begin
                    tx_next    = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_next = 1'b1;
                if (wrap) begin
                    if (buf_valid_reg) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Loading only happens while the buffer is full, when no accept can occur.
        if (load) begin
            sr_next        = buf_reg;
            buf_valid_next = 1'b0;
            tx_next        = 1'b0;
            cnt_next       = '0;
            state_next     = S_START;
`ifdef UART_TX_PARITY_EN
            parity_next    = par_chain[8];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_reg       <= 3'd0;
            sr_reg        <= 8'h00;
            tx_reg        <= 1'b1;
            buf_reg       <= 8'h00;
            buf_valid_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            sr_reg        <= sr_next;
            tx_reg        <= tx_next;
            buf_reg       <= buf_next;
            buf_valid_reg <= buf_valid_next;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

endmodule
